// File: rtl/ifft_pkg.sv
// Shared defaults, FSM state type and index bit-reversal helper for the IFFT
// parallel-to-serial streamer.
package ifft_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_N      = 16;
  localparam int MAX_IDX_W  = 6;

  typedef enum logic {
    IDLE   = 1'b0,
    SERIAL = 1'b1
  } state_t;

  // Reverses the low idx_w bits of idx; the caller zero-extends idx to MAX_IDX_W.
  function automatic logic [MAX_IDX_W-1:0] bitrev(input logic [MAX_IDX_W-1:0] idx,
                                                  input int idx_w);
    logic [MAX_IDX_W-1:0] rev;
    rev = {<<{idx}};
    return rev >> (MAX_IDX_W - idx_w);
  endfunction

endpackage

// File: rtl/ifft_frame_reg.sv
// N x DATA_W frame holding register with full flag and per-frame mode bit.
// Load has priority over clear so a buffer can empty and refill on one edge.
module ifft_frame_reg
  import ifft_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N      = DEF_N
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic                i_clear,
  input  logic [N*DATA_W-1:0] i_data,
  input  logic                i_mode,
  output logic [N*DATA_W-1:0] o_data,
  output logic                o_full,
  output logic                o_mode
);

  logic [N*DATA_W-1:0] r_data;
  logic                r_full;
  logic                r_mode;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
      r_full <= 1'b0;
      r_mode <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_full <= 1'b1;
      r_mode <= i_mode;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;
  assign o_mode = r_mode;

endmodule

// File: rtl/ifft_p2s_stream.sv
// Serialises parallel IFFT frames one sample per cycle (natural or bit-reversed order),
// first sample one cycle after accept; a shadow buffer hides frame turnaround, in_ready drops only while it is full.
module ifft_p2s_stream
  import ifft_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N      = DEF_N,
  parameter int IDX_W  = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic                in_bitrev,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_first,
  output logic                out_last,
  output logic                busy
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_rd_idx;

  logic [N*DATA_W-1:0] w_main_data;
  logic [N*DATA_W-1:0] w_shadow_data;
  logic [N*DATA_W-1:0] w_main_ld_data;
  logic                w_main_full;
  logic                w_shadow_full;
  logic                w_main_mode;
  logic                w_shadow_mode;
  logic                w_main_ld_mode;
  logic [DATA_W-1:0]   w_samples [N];

  logic w_accept;
  logic w_beat;
  logic w_last_beat;
  logic w_shift;
  logic w_main_free;
  logic w_main_load;
  logic w_shadow_load;

  assign in_ready      = !w_shadow_full;
  assign w_accept      = in_valid && !w_shadow_full;
  assign out_valid     = (r_state == SERIAL);
  assign w_beat        = out_valid && out_ready;
  assign w_last_beat   = w_beat && (r_idx == IDX_W'(N-1));
  // On the final beat the pending frame moves straight into main: no bubble.
  assign w_shift       = w_last_beat && w_shadow_full;
  assign w_main_free   = !w_main_full || w_last_beat;
  assign w_main_load   = w_shift || (w_accept && w_main_free);
  assign w_shadow_load = w_accept && !w_main_free;

  assign w_main_ld_data = w_shift ? w_shadow_data : in_data;
  assign w_main_ld_mode = w_shift ? w_shadow_mode : in_bitrev;

  ifft_frame_reg #(.DATA_W(DATA_W), .N(N)) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_load),
    .i_clear (w_last_beat),
    .i_data  (w_main_ld_data),
    .i_mode  (w_main_ld_mode),
    .o_data  (w_main_data),
    .o_full  (w_main_full),
    .o_mode  (w_main_mode)
  );

  ifft_frame_reg #(.DATA_W(DATA_W), .N(N)) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_shadow_load),
    .i_clear (w_shift),
    .i_data  (in_data),
    .i_mode  (in_bitrev),
    .o_data  (w_shadow_data),
    .o_full  (w_shadow_full),
    .o_mode  (w_shadow_mode)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_main_load) begin
        r_idx <= '0;
      end else if (w_beat) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_main_load) w_state_nxt = SERIAL;
      SERIAL:  if (w_last_beat && !w_main_load) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_samples[k] = w_main_data[k*DATA_W +: DATA_W];
    end
  end

  assign w_rd_idx  = w_main_mode ? IDX_W'(bitrev(MAX_IDX_W'(r_idx), IDX_W)) : r_idx;
  assign out_data  = out_valid ? w_samples[w_rd_idx] : '0;
  assign out_first = out_valid && (r_idx == '0);
  assign out_last  = out_valid && (r_idx == IDX_W'(N-1));
  assign busy      = out_valid;

endmodule

// File: doc/ifft_p2s_stream.md
IFFT_P2S_STREAM -- requirements
Module: ifft_p2s_stream

Interface
REQ-001 Parameter DATA_W, default 16, sample width in bits.
REQ-002 Parameter N, default 16, samples per frame; power of two, 4..64.
REQ-003 Parameter IDX_W, default $clog2(N), width of the sample index.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  parallel frame present on in_data.
REQ-007 in_data  in  N*DATA_W  frame; sample k at bits [k*DATA_W +: DATA_W].
REQ-008 in_bitrev  in  1  output-order mode for this frame, sampled with the frame (1 = bit-reversed index order).
REQ-009 in_ready  out  1  block can accept a frame this cycle.
REQ-010 out_valid  out  1  out_data holds a valid sample.
REQ-011 out_ready  in  1  downstream accepts the sample this cycle.
REQ-012 out_data  out  DATA_W  current serial sample.
REQ-013 out_first  out  1  current sample is index 0 of its frame.
REQ-014 out_last  out  1  current sample is index N-1 of its frame.
REQ-015 busy  out  1  main buffer holds an unfinished frame.

Function
REQ-016 Two frame buffers: main (being serialised) and shadow (pending); each has a full flag and a stored mode bit.
REQ-017 Input handshake: a frame is accepted when in_valid && in_ready; in_ready = !shadow_full, combinational from registers only.
REQ-018 Accepted frame goes to main if main is empty, or empties on the same edge; otherwise it goes to shadow.
REQ-019 FSM states: IDLE (main empty) and SERIAL (main full).
  - IDLE -> SERIAL on frame load.
  - SERIAL -> IDLE after the last beat if no frame is pending.
  - Otherwise the FSM stays in SERIAL.
REQ-020 In SERIAL, out_valid = 1; out_data = main[idx] in natural mode, or main[bitrev(idx)] in bitrev mode; idx starts at 0.
REQ-021 Output beat = out_valid && out_ready.
  - Each beat increments idx.
  - With out_ready = 0, idx, out_data, out_first and out_last hold stable.
REQ-022 out_first = (idx == 0) && out_valid; out_last = (idx == N-1) && out_valid.
REQ-023 Latency: first sample valid one cycle after the accepting edge.
REQ-024 Last beat with shadow full: on the same edge shadow moves to main, idx returns to 0 and shadow empties; no bubble cycle, so out_valid stays 1.
REQ-025 Last beat with shadow empty and no frame accepted that cycle: FSM goes to IDLE and out_valid = 0 the next cycle.
REQ-026 Last beat with shadow empty and a frame accepted that cycle: the frame loads into main directly, back-to-back.
REQ-027 Sustained throughput: one sample per cycle, with in_ready deasserted only while shadow is full.
REQ-028 Mode bit is per frame; in_bitrev changes never affect a frame already buffered.
REQ-029 In IDLE, out_data = 0, out_first = 0, out_last = 0.
REQ-030 busy = (state == SERIAL).

Reset
REQ-031 While rst = 0, all of the following are zero: both buffers, full flags, mode bits, idx and state (IDLE).
REQ-032 Outputs during reset: out_valid = 0, out_data = 0, out_first = 0, out_last = 0, busy = 0, in_ready = 1.
REQ-033 A reset mid-frame discards main and shadow contents; no partial frame resumes after reset release.

Structure
REQ-034 Shared package ifft_pkg holds:
  - DATA_W and N defaults;
  - the state enum (IDLE, SERIAL);
  - a bitrev(idx) function parameterised by IDX_W.
REQ-035 Sub-module ifft_frame_reg (N x DATA_W register bank with load enable, full flag and mode bit) is instantiated twice, once as main and once as shadow.

Verification (N=16, DATA_W=16)
REQ-036 Load frame in_data[k] = 16'h0100+k, natural mode, out_ready = 1 -> 16 beats 0100..010F; first on beat 0, last on beat 15; out_valid falls on the following cycle.
REQ-037 Same frame with in_bitrev = 1 -> output order 0100, 0108, 0104, 010C, 0102, ... 010F.
REQ-038 Three frames offered back-to-back with in_valid held high -> 48 contiguous beats; in_ready low while shadow is full; no gap between frames.
REQ-039 out_ready toggling 1,0,0,1 during a frame -> each sample held unchanged while stalled; no sample dropped or duplicated.
REQ-040 rst pulsed low at beat 7 with shadow full -> all outputs 0 and in_ready = 1 during reset; after release a new frame starts at index 0 with out_first = 1.
